pong_match_ctrl: RTL
====================

// Module: pong_match_ctrl
// PURPOSE
//  Match sequencer for the pong datapath: owns game-phase FSM (new game, serve wait, play, pause, over).
//  Drives gra_still to the graph unit and d_clr/point_inc to the score counter; tracks balls and scores.
//  Enforces timed hold-offs and win-by-score. Sits between input selection (buttons/keyboard) and pong_graph/score_counter.
// PARAMETERS
//  BALLS        3    balls per match (1..7)
//  WIN_SCORE    5    points that end the match immediately (1..2**SCORE_W-1)
//  SCORE_W      4    width of internal per-player point counters
//  HOLD_FRAMES  120  frame_tick count for serve/over hold-off (2 s at 60 Hz)
// PORTS
//  top_clk     in   1        system clock (100 MHz)
//  reset       in   1        synchronous, active-high reset
//  frame_tick  in   1        1-cycle pulse per video frame
//  start_req   in   1        level: any player paddle key/button held
//  pause_req   in   1        level: pause key; acted on at rising edge only
//  miss        in   2        1-cycle pulses from pong_graph; [0]=left missed, [1]=right missed
//  gra_still   out  1        1 = freeze ball/paddles
//  d_clr       out  1        clear score_counter
//  point_inc   out  2        1-cycle pulse; [0]=left scores, [1]=right scores
//  state       out  3        current phase (pkg encoding) for text/rgb mux
//  balls_left  out  3        balls remaining incl. current
//  serve_dir   out  1        0 = serve toward left, 1 = toward right
//  winner      out  2        01 left, 10 right, 00 none/draw; valid in OVER
// BEHAVIOUR
//  All outputs registered; reset: state=NEWGAME, gra_still=1, d_clr=1, point_inc=0, balls_left=BALLS,
//   serve_dir=0, winner=0, score counters=0, timer idle, pause edge register=0. Reset wins over any event.
//  NEWGAME: gra_still=1, d_clr=1, balls/scores/winner reloaded. start_req high -> PLAY next cycle, d_clr=0.
//  PLAY: gra_still=0. Miss handling, one cycle:
//   miss[0] -> point_inc=2'b10, right score+1, serve_dir=0 (toward loser); miss[1] -> 2'b01, left+1, serve_dir=1.
//   miss==2'b11 same cycle: miss[0] only is honoured.
//   balls_left-1; if scorer reaches WIN_SCORE or balls_left was 1 -> OVER, else -> SERVE; timer restarts.
//   pause_req rising edge with no miss -> PAUSE; miss beats pause in same cycle.
//  PAUSE: gra_still=1; misses ignored; next pause_req rising edge -> PLAY. No timer.
//  SERVE: gra_still=1; -> PLAY when timer_up && start_req (start held through expiry counts).
//  OVER: gra_still=1; winner = higher score (equal -> 00), set on entry; -> NEWGAME when timer_up.
//  Timer: counts frame_tick from 0; timer_up when count==HOLD_FRAMES, sticky until restart;
//   restart clears count same cycle; frame_tick coincident with restart is not counted.
//  Score counters saturate at 2**SCORE_W-1 (never wrap); point_inc still pulses.
//  point_inc is a 1-cycle pulse aligned with the state change; never asserted outside PLAY exit cycle.
// STRUCTURE
//  pong_pkg: state encodings (NEWGAME=0, PLAY=1, SERVE=2, PAUSE=3, OVER=4), WINNER_* constants.
//  Sub-module hold_timer (top_clk, reset, restart, frame_tick, HOLD_FRAMES -> timer_up);
//  FSM, ball/score counters and pause edge detect stay in pong_match_ctrl.
// TESTING
//  1 reset, start_req=1 for 1 cycle -> state NEWGAME->PLAY, d_clr 1->0, gra_still 0, balls_left=3.
//  2 PLAY, miss=01 -> point_inc=10 one cycle, state=SERVE, balls_left=2, serve_dir=0; start_req held,
//    SERVE exits to PLAY exactly on the cycle after frame 120.
//  3 BALLS=3: three misses miss=10 -> left score 3, third miss goes OVER, winner=01; 120 frames -> NEWGAME.
//  4 WIN_SCORE=2, BALLS=7: two miss=01 -> OVER after 2nd, balls_left=5, winner=10.
//  5 PLAY, miss=11 and pause edge same cycle -> only point_inc=10, state=SERVE; no PAUSE entry.
//  6 PAUSE: miss pulses ignored, pause held high no exit, release/re-press -> PLAY; reset mid-SERVE at frame 60 -> NEWGAME, all reset values.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared encodings for the pong match sequencer: game phases, winner codes
// and point-pulse codes.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_NEWGAME = 3'd0,
      ST_PLAY    = 3'd1,
      ST_SERVE   = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_OVER    = 3'd4
   } state_t;

   localparam logic [1:0] WINNER_NONE  = 2'b00;
   localparam logic [1:0] WINNER_LEFT  = 2'b01;
   localparam logic [1:0] WINNER_RIGHT = 2'b10;

   localparam logic [1:0] PT_NONE  = 2'b00;
   localparam logic [1:0] PT_LEFT  = 2'b01;
   localparam logic [1:0] PT_RIGHT = 2'b10;

endpackage

// File: rtl/hold_timer.sv
// Frame-counting hold-off timer: counts frame_tick pulses after a restart and
// raises a sticky timer_up once HOLD_FRAMES frames have elapsed.
module hold_timer #(
   parameter int HOLD_FRAMES = 120
) (
   input  logic top_clk,
   input  logic reset,
   input  logic restart,
   input  logic frame_tick,
   output logic timer_up
);

   localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
   localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_FRAMES);

   logic [CNT_W-1:0] count_q, count_d;

   // Restart wins over a coincident frame_tick; the count parks at HOLD so
   // timer_up stays high until the next restart.
   always_comb begin
      count_d = count_q;
      if (restart)
         count_d = '0;
      else if (frame_tick && (count_q != HOLD))
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge top_clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign timer_up = (count_q == HOLD);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game-phase FSM, ball and per-player score tracking,
// pause edge detection, and the freeze/clear/point controls for the datapath.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int BALLS       = 3,
   parameter int WIN_SCORE   = 5,
   parameter int SCORE_W     = 4,
   parameter int HOLD_FRAMES = 120
) (
   input  logic       top_clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start_req,
   input  logic       pause_req,
   input  logic [1:0] miss,
   output logic       gra_still,
   output logic       d_clr,
   output logic [1:0] point_inc,
   output logic [2:0] state,
   output logic [2:0] balls_left,
   output logic       serve_dir,
   output logic [1:0] winner
);

   localparam logic [2:0]         BALLS_INIT = 3'(BALLS);
   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

   state_t             state_q, state_d;
   logic               gra_still_q, gra_still_d;
   logic               d_clr_q, d_clr_d;
   logic [1:0]         point_inc_q, point_inc_d;
   logic [2:0]         balls_q, balls_d;
   logic               serve_dir_q, serve_dir_d;
   logic [1:0]         winner_q, winner_d;
   logic [SCORE_W-1:0] score_l_q, score_l_d;
   logic [SCORE_W-1:0] score_r_q, score_r_d;
   logic [SCORE_W-1:0] scorer_new;
   logic               pause_prev_q;
   logic               pause_rise;
   logic               restart;
   logic               timer_up;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s == SCORE_MAX) ? s : s + 1'b1;
   endfunction

   assign pause_rise = pause_req & ~pause_prev_q;

   hold_timer #(.HOLD_FRAMES(HOLD_FRAMES)) u_hold_timer (
      .top_clk    (top_clk),
      .reset      (reset),
      .restart    (restart),
      .frame_tick (frame_tick),
      .timer_up   (timer_up)
   );

   always_comb begin
      state_d     = state_q;
      gra_still_d = gra_still_q;
      d_clr_d     = d_clr_q;
      point_inc_d = PT_NONE;
      balls_d     = balls_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      scorer_new  = '0;
      restart     = 1'b0;
      unique case (state_q)
         ST_NEWGAME: begin
            if (start_req) begin
               state_d     = ST_PLAY;
               gra_still_d = 1'b0;
               d_clr_d     = 1'b0;
            end
         end
         ST_PLAY: begin
            // Both sides missing in one cycle is scored as a left miss only.
            if (miss != 2'b00) begin
               if (miss[0]) begin
                  score_r_d   = sat_inc(score_r_q);
                  scorer_new  = score_r_d;
                  point_inc_d = PT_RIGHT;
                  serve_dir_d = 1'b0;
               end else begin
                  score_l_d   = sat_inc(score_l_q);
                  scorer_new  = score_l_d;
                  point_inc_d = PT_LEFT;
                  serve_dir_d = 1'b1;
               end
               balls_d     = balls_q - 1'b1;
               gra_still_d = 1'b1;
               restart     = 1'b1;
               if ((scorer_new >= WIN) || (balls_q == 3'd1)) begin
                  state_d  = ST_OVER;
                  winner_d = (score_l_d > score_r_d) ? WINNER_LEFT  :
                             (score_r_d > score_l_d) ? WINNER_RIGHT : WINNER_NONE;
               end else begin
                  state_d = ST_SERVE;
               end
            end else if (pause_rise) begin
               state_d     = ST_PAUSE;
               gra_still_d = 1'b1;
            end
         end
         ST_PAUSE: begin
            if (pause_rise) begin
               state_d     = ST_PLAY;
               gra_still_d = 1'b0;
            end
         end
         ST_SERVE: begin
            if (timer_up && start_req) begin
               state_d     = ST_PLAY;
               gra_still_d = 1'b0;
            end
         end
         ST_OVER: begin
            if (timer_up) begin
               state_d     = ST_NEWGAME;
               gra_still_d = 1'b1;
               d_clr_d     = 1'b1;
               balls_d     = BALLS_INIT;
               score_l_d   = '0;
               score_r_d   = '0;
               winner_d    = WINNER_NONE;
            end
         end
         default: state_d = ST_NEWGAME;
      endcase
   end

   always_ff @(posedge top_clk) begin
      if (reset) begin
         state_q      <= ST_NEWGAME;
         gra_still_q  <= 1'b1;
         d_clr_q      <= 1'b1;
         point_inc_q  <= PT_NONE;
         balls_q      <= BALLS_INIT;
         serve_dir_q  <= 1'b0;
         winner_q     <= WINNER_NONE;
         score_l_q    <= '0;
         score_r_q    <= '0;
         pause_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         gra_still_q  <= gra_still_d;
         d_clr_q      <= d_clr_d;
         point_inc_q  <= point_inc_d;
         balls_q      <= balls_d;
         serve_dir_q  <= serve_dir_d;
         winner_q     <= winner_d;
         score_l_q    <= score_l_d;
         score_r_q    <= score_r_d;
         pause_prev_q <= pause_req;
      end
   end

   assign state      = state_q;
   assign gra_still  = gra_still_q;
   assign d_clr      = d_clr_q;
   assign point_inc  = point_inc_q;
   assign balls_left = balls_q;
   assign serve_dir  = serve_dir_q;
   assign winner     = winner_q;

endmodule
